enable_counter: RTL and testbench



---
 rtl/enable_counter_pkg.sv | 17 +
 rtl/enable_counter.sv | 54 +++++
 tb/tb_enable_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/enable_counter_pkg.sv
// Shared definitions for the enable_counter block: default sizing and the
// parameter legality rule used at elaboration.
package enable_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 31;

    // Legal when 1 <= width <= MAX_WIDTH and 2 <= modulus <= 2**width.
    function automatic bit counter_params_legal(input int unsigned width,
                                                input int unsigned modulus);
        if (width < 1 || width > MAX_WIDTH) begin
            return 1'b0;
        end
        return (modulus >= 2) && (modulus <= (32'd1 << width));
    endfunction

endpackage

// File: rtl/enable_counter.sv
// Gated up-counter modulo MODULUS with an asynchronous active-low reset.
// The count is the only state and is presented directly as a registered output.
module enable_counter
    import enable_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             reset,
    output logic [WIDTH-1:0] data
);

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_next;

    // Reject illegal sizing before anything is built.
    if (!counter_params_legal(WIDTH, MODULUS)) begin : g_param_check
        $error("enable_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    // Increment with wrap at MODULUS-1; hold when not enabled.
    always_comb begin
        count_next = data;
        if (enable) begin
            if (data == COUNT_MAX) begin
                count_next = '0;
            end else begin
                count_next = data + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else begin
            data <= count_next;
        end
    end

`ifndef SYNTHESIS
    // An unknown enable only matters while the counter is out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(enable))
            else $error("enable_counter: enable is X/Z while out of reset");
        end
    end
`endif

endmodule

// File: tb/tb_enable_counter.sv
// Directed bench for enable_counter: a default modulo-16 instance and a
// modulo-10 instance share clock, enable and reset.
module tb_enable_counter;

    logic       clk;
    logic       enable;
    logic       reset;
    logic [3:0] data16;
    logic [3:0] data10;

    int checks;
    int errors;

    enable_counter u_dut16 (
        .clk    (clk),
        .enable (enable),
        .reset  (reset),
        .data   (data16)
    );

    enable_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk    (clk),
        .enable (enable),
        .reset  (reset),
        .data   (data10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b0;

        // Reset takes hold before the first clock edge.
        #3;
        check_val("reset_pre_clk16", data16, 4'd0);
        check_val("reset_pre_clk10", data10, 4'd0);

        // Reset hold with enable toggling.
        for (int i = 0; i < 5; i++) begin
            enable = ~enable;
            step();
            check_val("reset_hold", data16, 4'd0);
        end

        // Release with enable high: first increment on the next edge.
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_val("count16", data16, 4'(i));
            check_val("count10", data10, 4'(i));
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold", data16, 4'd5);
        end

        // Mid-cycle reset clears without a clock edge.
        reset = 1'b0;
        #2;
        check_val("async_clear16", data16, 4'd0);
        check_val("async_clear10", data10, 4'd0);
        step();

        // Wrap: modulo-16 and modulo-10 sequences from 0.
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            check_val("wrap16", data16, 4'(i % 16));
            check_val("wrap10", data10, 4'(i % 10));
        end

        // Reset in the middle of counting, with enable still high.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check_val("pre_reset_7", data16, 4'd7);
        reset = 1'b0;
        #2;
        check_val("mid_count_clear", data16, 4'd0);
        step();
        check_val("reset_wins_edge", data16, 4'd0);
        reset = 1'b1;
        step();
        check_val("post_release_1", data16, 4'd1);

        // Enable gating: alternating 1/0 from 0 gives 1,1,2,2,3,3,4,4.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            step();
            check_val("gating16", data16, 4'((i + 2) / 2));
            check_val("gating10", data10, 4'((i + 2) / 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
